// File: rtl/serout_arb.sv
// Round-robin arbiter that shares one serout 128-bit serial generator among NREQ producers.
// Grants a word, restarts serout, enables it until ready (or watchdog), then acks the producer.
module serout_arb #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 2000000,
    parameter int TO_W    = 21
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [128*NREQ-1:0]    reqdata,
    output logic [NREQ-1:0]        ack,
    output logic                   err,
    output logic                   busy,
    output logic                   so_rst,
    output logic                   so_en,
    output logic [127:0]           so_ptdata,
    input  logic                   so_ready
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

    state_t           state, state_n;
    logic [IDX_W-1:0] ptr, gidx, sel;
    logic             found;
    logic [TO_W-1:0]  cnt;
    logic             ld;
    logic             err_pending;
    logic [127:0]     selword;

    // First set request scanning from ptr upward, wrapping mod NREQ.
    always_comb begin
        int idx;
        idx   = 0;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        selword = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (sel == IDX_W'(k)) selword = reqdata[128*k +: 128];
        end
    end

    // Ready seen on the first SEND cycle may be left over from the previous transfer.
    always_comb begin
        state_n     = state;
        err_pending = 1'b0;
        case (state)
            IDLE: if (found) state_n = LOAD;
            LOAD: if (ld) state_n = SEND;
            SEND: begin
                if (cnt != '0 && so_ready) begin
                    state_n = DONE;
                end else if (cnt == TO_LAST) begin
                    state_n     = DONE;
                    err_pending = 1'b1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            gidx      <= '0;
            cnt       <= '0;
            ld        <= 1'b0;
            so_rst    <= 1'b1;
            so_en     <= 1'b0;
            so_ptdata <= '0;
            ack       <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state  <= state_n;
            so_en  <= (state_n == SEND);
            so_rst <= (state_n != SEND);
            busy   <= (state_n != IDLE);
            ack    <= '0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    ld  <= 1'b0;
                    if (found) begin
                        gidx      <= sel;
                        so_ptdata <= selword;
                    end
                end
                LOAD: ld <= 1'b1;
                SEND: begin
                    cnt <= cnt + 1'b1;
                    if (state_n == DONE) begin
                        ack <= NREQ'(1) << gidx;
                        err <= err_pending;
                    end
                end
                DONE: begin
                    if (int'(gidx) == NREQ - 1) ptr <= '0;
                    else                        ptr <= gidx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serout_arb.sv
// Directed bench for serout_arb with a simple serout ready model.
module tb_serout_arb;

    localparam int NREQ = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [NREQ-1:0]  req;
    logic [511:0]     reqdata;
    logic [NREQ-1:0]  ack;
    logic             err;
    logic             busy;
    logic             so_rst;
    logic             so_en;
    logic [127:0]     so_ptdata;
    logic             so_ready;

    int errors = 0;
    int checks = 0;

    // serout model: ready rises after ready_dly enabled cycles, cleared by its reset
    logic model_ready = 1'b0;
    logic stale_force = 1'b0;
    bit   never_ready = 1'b0;
    int   en_cnt      = 0;
    int   ready_dly   = 40;

    assign so_ready = model_ready | stale_force;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (so_rst) begin
            en_cnt      <= 0;
            model_ready <= 1'b0;
        end else if (so_en) begin
            en_cnt      <= en_cnt + 1;
            model_ready <= !never_ready && (en_cnt + 1 >= ready_dly);
        end
    end

    serout_arb #(.NREQ(NREQ), .TIMEOUT(50), .TO_W(8)) dut (
        .clk(clk), .rst(rst), .req(req), .reqdata(reqdata), .ack(ack), .err(err),
        .busy(busy), .so_rst(so_rst), .so_en(so_en), .so_ptdata(so_ptdata), .so_ready(so_ready)
    );

    // Waits for an ack (bounded), clears the acked req bits like a real requester.
    task automatic wait_ack(input int maxcyc, output logic [NREQ-1:0] a, output logic e,
                            output int ens, output bit ok);
        ok = 1'b0; a = '0; e = 1'b0; ens = 0;
        for (int c = 0; c < maxcyc; c++) begin
            @(negedge clk);
            if (ack != '0) begin
                a = ack; e = err; ok = 1'b1;
                req = req & ~ack;
                return;
            end
            if (so_en) ens++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({so_rst, so_en, ack, err, busy} !== {1'b1, 1'b0, 4'b0000, 1'b0, 1'b0} || so_ptdata !== '0) begin
            errors++;
            $display("FAIL reset_values: rst=%b en=%b ack=%b err=%b busy=%b pt=%h, want 1 0 0000 0 0 0",
                     so_rst, so_en, ack, err, busy, so_ptdata);
        end
    endtask

    task automatic test_single();
        logic [NREQ-1:0] a; logic e; int ens; bit ok; int pre;
        reqdata[127:0] = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        req = 4'b0001;
        pre = 0;
        for (int c = 0; c < 10 && !so_en; c++) begin
            if (so_rst) pre++;
            @(negedge clk);
        end
        checks++;
        if (pre !== 3 || so_en !== 1'b1) begin
            errors++;
            $display("FAIL single_rst_before_en: got %0d cycles (en=%b), want 3", pre, so_en);
        end
        checks++;
        if (so_ptdata !== 128'h00112233_44556677_8899AABB_CCDDEEFF) begin
            errors++;
            $display("FAIL single_ptdata: got %h want 00112233445566778899aabbccddeeff", so_ptdata);
        end
        wait_ack(200, a, e, ens, ok);
        checks++;
        if (!ok || a !== 4'b0001 || e !== 1'b0) begin
            errors++;
            $display("FAIL single_ack: ok=%b ack=%b err=%b, want ack=0001 err=0", ok, a, e);
        end
        @(negedge clk);
        checks++;
        if (ack !== 4'b0000 || busy !== 1'b0 || dut.ptr !== 2'd1) begin
            errors++;
            $display("FAIL single_after: ack=%b busy=%b ptr=%0d, want 0000 0 1", ack, busy, dut.ptr);
        end
    endtask

    task automatic test_stale_ready();
        logic [NREQ-1:0] a; logic e; int ens; bit ok;
        stale_force = 1'b1;
        req = 4'b0010;
        for (int c = 0; c < 10 && !so_en; c++) @(negedge clk);
        // keep stale ready through the edge that ends the first SEND cycle
        @(posedge clk);
        #1 stale_force = 1'b0;
        @(negedge clk);
        checks++;
        if (so_en !== 1'b1 || ack !== 4'b0000) begin
            errors++;
            $display("FAIL stale_ready: en=%b ack=%b, want en=1 ack=0000", so_en, ack);
        end
        wait_ack(200, a, e, ens, ok);
        checks++;
        if (!ok || a !== 4'b0010 || e !== 1'b0 || ens < 30) begin
            errors++;
            $display("FAIL stale_complete: ok=%b ack=%b err=%b en_cycles=%0d, want 0010 0 >=30",
                     ok, a, e, ens);
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] a; logic e; int ens; bit ok;
        logic [NREQ-1:0] exp_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        ready_dly = 3;
        do_reset();
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_ack(200, a, e, ens, ok);
            checks++;
            if (!ok || a !== exp_seq[n]) begin
                errors++;
                $display("FAIL rr_grant%0d: ok=%b ack=%b want %b", n, ok, a, exp_seq[n]);
            end
            if (n < 4) begin
                @(negedge clk);
                req = 4'b1111;
            end else begin
                req = 4'b0000;
            end
        end
        req = 4'b0010;
        wait_ack(200, a, e, ens, ok);
        @(negedge clk);
        checks++;
        if (!ok || a !== 4'b0010 || dut.ptr !== 2'd2) begin
            errors++;
            $display("FAIL rr_setup: ok=%b ack=%b ptr=%0d, want 0010 ptr 2", ok, a, dut.ptr);
        end
        req = 4'b0011;
        wait_ack(200, a, e, ens, ok);
        req = 4'b0000;
        checks++;
        if (!ok || a !== 4'b0001) begin
            errors++;
            $display("FAIL rr_wrap: ok=%b ack=%b want 0001", ok, a);
        end
        @(negedge clk);
        ready_dly = 40;
    endtask

    task automatic test_timeout();
        logic [NREQ-1:0] a; logic e; int ens; bit ok;
        never_ready = 1'b1;
        req = 4'b0100;
        wait_ack(300, a, e, ens, ok);
        checks++;
        if (!ok || a !== 4'b0100 || e !== 1'b1 || ens !== 50 || so_en !== 1'b0) begin
            errors++;
            $display("FAIL timeout: ok=%b ack=%b err=%b send_cycles=%0d en=%b, want 0100 1 50 0",
                     ok, a, e, ens, so_en);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_after: busy=%b err=%b want 0 0", busy, err);
        end
        never_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [NREQ-1:0] a; logic e; int ens; bit ok;
        req = 4'b1000;
        for (int c = 0; c < 10 && !so_en; c++) @(negedge clk);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (so_en !== 1'b0 || so_rst !== 1'b1 || ack !== 4'b0000 || busy !== 1'b0 || dut.ptr !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset: en=%b rst=%b ack=%b busy=%b ptr=%0d, want 0 1 0000 0 0",
                     so_en, so_rst, ack, busy, dut.ptr);
        end
        @(negedge clk);
        rst = 1'b0;
        wait_ack(200, a, e, ens, ok);
        checks++;
        if (!ok || a !== 4'b1000 || e !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_regrant: ok=%b ack=%b err=%b want 1000 0", ok, a, e);
        end
        @(negedge clk);
    endtask

    task automatic test_snapshot();
        logic [NREQ-1:0] a; logic e; int ens; bit ok; bit bad;
        reqdata[255:128] = 128'hA5A5A5A5_11111111_22222222_33333333;
        req = 4'b0010;
        for (int c = 0; c < 10 && !so_en; c++) @(negedge clk);
        reqdata[255:128] = 128'h5A5A5A5A_99999999_88888888_77777777;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (so_ptdata !== 128'hA5A5A5A5_11111111_22222222_33333333) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL snapshot_send: got %h want a5a5a5a5111111112222222233333333", so_ptdata);
        end
        wait_ack(200, a, e, ens, ok);
        checks++;
        if (!ok || a !== 4'b0010 || so_ptdata !== 128'hA5A5A5A5_11111111_22222222_33333333) begin
            errors++;
            $display("FAIL snapshot_done: ok=%b ack=%b pt=%h want 0010 a5a5...3333", ok, a, so_ptdata);
        end
        @(negedge clk);
        req = 4'b0010;
        for (int c = 0; c < 10 && !so_en; c++) @(negedge clk);
        checks++;
        if (so_ptdata !== 128'h5A5A5A5A_99999999_88888888_77777777) begin
            errors++;
            $display("FAIL snapshot_next: got %h want 5a5a5a5a999999998888888877777777", so_ptdata);
        end
        wait_ack(200, a, e, ens, ok);
        req = 4'b0000;
    endtask

    initial begin
        rst     = 1'b1;
        req     = '0;
        reqdata = '0;
        test_reset();
        test_single();
        test_stale_ready();
        test_round_robin();
        test_timeout();
        test_mid_reset();
        test_snapshot();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serout_arb.md
Name: serout_arb

Overview:
- Round-robin arbiter and sequencer sharing one serout 128-bit serial output generator among NREQ result producers (e.g. MD5 cracking cores).
- Latches the winning requester's 128-bit word and restarts serout through its reset.
- Enables serout until it reports ready, then acknowledges the requester.
- Includes a watchdog so a hung transmitter cannot lock the port.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 2000000, max SEND cycles before abort (> 16 bytes at 9600 baud on 50 MHz plus busywait gaps).
- TO_W, 21, watchdog counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester valid; held until ack.
- reqdata  in  128*NREQ  flattened data; requester i uses bits [128*i+127 : 128*i]; stable while req[i]=1.
- ack  out  NREQ  one-cycle completion pulse to the granted requester.
- err  out  1  one-cycle pulse with ack when the transfer aborted on timeout.
- busy  out  1  high in any state other than IDLE.
- so_rst  out  1  drives serout rst (serout resets synchronously).
- so_en  out  1  drives serout en.
- so_ptdata  out  128  drives serout ptdata; MSB byte is sent first.
- so_ready  in  1  serout ready.

Behaviour:
- All outputs are registered. Reset is asynchronous, active-high: one clock, asynchronous active-high reset (rst).
- Reset values:
  - state=IDLE, ptr=0, cnt=0
  - so_rst=1, so_en=0, so_ptdata=0
  - ack=0, err=0, busy=0
- States: IDLE, LOAD, SEND, DONE.
- IDLE:
  - so_rst=1, so_en=0.
  - If any req bit is set, select the first set bit scanning ptr, ptr+1, ..., wrapping mod NREQ.
  - Latch its word into so_ptdata and its index into gidx; cnt<=0; go to LOAD.
  - With no requests, remain in IDLE.
- LOAD:
  - Exactly 2 cycles; so_rst=1, so_en=0.
  - Needed because serout's ready can stay high for one reset cycle from the previous transfer.
  - Then go to SEND.
- SEND:
  - so_rst=0, so_en=1; cnt increments each cycle.
  - so_ready is ignored on the first SEND cycle.
  - From the second cycle on, so_ready=1 goes to DONE with err_pending=0.
  - If cnt reaches TIMEOUT-1 without ready, go to DONE with err_pending=1.
- DONE:
  - 1 cycle; so_en=0, so_rst=1.
  - ack[gidx]=1; err=err_pending.
  - ptr<=(gidx+1) mod NREQ; then go to IDLE.
- Requester contract:
  - The requester clears req[i] on the edge where it samples ack[i]=1, so IDLE never re-grants the same word.
  - A requester re-raising req in a later cycle is a new transfer.
- Data snapshot: so_ptdata is captured only in IDLE. Changes to reqdata or req during LOAD/SEND do not affect the transfer in flight.
- Dropped requests: a requester that drops req before its grant is simply skipped. A requester that drops req after its grant still receives its ack.
- busy = (state != IDLE).
- Simultaneous requests: the grant goes to the lowest index at or above ptr (wrapped). With persistent requests, no requester is granted twice before every other active requester has been granted once.
- Mid-operation reset: asynchronous reset in any state immediately returns to IDLE with reset values. so_rst=1 aborts serout; no ack is issued.
- Minimum cycles per transfer excluding serout time: 1 IDLE + 2 LOAD + 2 SEND + 1 DONE.

Test Plan:
- Single request: req=4'b0001, reqdata[127:0]=128'h00112233_44556677_8899AABB_CCDDEEFF with a serout model asserting ready 40 cycles after en.
  - Expect so_ptdata equal to that word, so_rst high exactly 3 cycles (IDLE + 2 LOAD) before so_en rises.
  - Expect ack=4'b0001 one cycle, err=0, ptr=1.
- Stale ready: hold so_ready=1 through LOAD and the first SEND cycle, then drop it.
  - Expect no DONE on the first SEND cycle and the transfer to continue.
- Round-robin: req=4'b1111 held, each requester clearing and re-raising after ack.
  - Expect the ack sequence 0,1,2,3,0.
  - Then with ptr=2 and req=4'b0011, expect the grant to go to 0.
- Timeout: TIMEOUT=50, model never asserts ready.
  - Expect ack and err together exactly 50 SEND cycles after entry, so_en low in DONE, busy low the next cycle.
- Mid-transfer reset: assert rst during SEND.
  - Expect so_en=0, so_rst=1, ack=0, busy=0, ptr=0 immediately.
  - A pending req is re-granted after rst releases.
- Data snapshot: change reqdata[1] during SEND of requester 1.
  - Expect so_ptdata unchanged until the next IDLE grant.
